// File: rtl/mem_port_ctrl_if.sv
// Request/response handshake bundle between a client and mem_port_ctrl.
// master = client side, slave = controller side.
interface mem_port_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Single-port request front end for a 1-cycle-latency dual-address RAM with a 3-entry read response FIFO.
// Optional out-of-range address checking is enabled by defining MEM_ADDR_CHECK_EN.
module mem_port_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  mem_port_ctrl_if.slave   bus,
  output logic [WIDTH-1:0] o_mem_data,
  output logic [AW-1:0]    o_mem_wraddress,
  output logic             o_mem_wren,
  output logic [AW-1:0]    o_mem_rdaddress,
  output logic             o_mem_rden,
  input  logic [WIDTH-1:0] i_mem_q,
  output logic             o_addr_err
);

  logic [WIDTH-1:0] r_fifo [3];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_inflight;
  logic             r_inflight_bad;

  logic             w_bad;
  logic             w_accept;
  logic             w_rd_acc;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_occ;
  logic [WIDTH-1:0] w_push_data;

  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef MEM_ADDR_CHECK_EN
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  logic r_addr_err;

  assign w_bad = ({1'b0, bus.req_addr} >= LP_DEPTH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_addr_err <= 1'b0;
    else if (w_accept && w_bad) r_addr_err <= 1'b1;
  end

  assign o_addr_err = r_addr_err;
`else
  assign w_bad      = 1'b0;
  assign o_addr_err = 1'b0;
`endif

  // Reads not yet popped (queued plus the one in the RAM pipe) bound the accept window.
  assign w_occ         = {1'b0, r_count} + {2'b00, r_inflight};
  assign bus.req_ready = !i_rst && (w_occ < 3'd3);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_rd_acc      = w_accept && !bus.req_we;

  assign o_mem_wren      = w_accept && bus.req_we && !w_bad;
  assign o_mem_wraddress = bus.req_addr;
  assign o_mem_data      = bus.req_wdata;
  assign o_mem_rden      = w_rd_acc && !w_bad;
  assign o_mem_rdaddress = bus.req_addr;

  assign bus.rsp_valid = (r_count != 2'd0);
  assign bus.rsp_data  = bus.rsp_valid ? r_fifo[r_rd_ptr] : '0;

  assign w_push      = r_inflight;
  assign w_pop       = bus.rsp_valid && bus.rsp_ready;
  assign w_push_data = r_inflight_bad ? '0 : i_mem_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr       <= 2'd0;
      r_rd_ptr       <= 2'd0;
      r_count        <= 2'd0;
      r_inflight     <= 1'b0;
      r_inflight_bad <= 1'b0;
    end else begin
      r_inflight     <= w_rd_acc;
      r_inflight_bad <= w_rd_acc && w_bad;
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; rsp_data is masked by rsp_valid instead.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

endmodule
